gshare_predictor: RTL

Parametrised global-history branch predictor for the five-stage MIPS pipeline. It is the configurable successor to the fixed global predictor. It keeps a speculative global history register (GHR) and a pattern history table (PHT) of saturating counters. It predicts combinationally for the instruction in Fetch and trains from the resolved branch. On a misprediction it restores the GHR from the snapshot the pipeline carried with the branch. A reset-time sweep FSM initialises the whole PHT.

---
 rtl/gshare_if.sv | 38 +++
 rtl/gshare_predictor.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/gshare_if.sv
// Bundles the fetch-side predict port and the resolve-side train port of the branch predictor.
// No logic and no latency; it only groups signals.
// No backpressure: the predictor accepts every predict and update request in the cycle it is presented.
//
// Ports (as seen by the predictor, slave modport):
//   pcF, branchF, stallF         fetch-stage request
//   predict_takenF, ghr_snapF    combinational prediction and history snapshot
//   update_en, update_pc, update_taken, update_snap, mispredict   resolved-branch training
//   ready                        PHT initialisation complete
interface gshare_if #(
    parameter int HIST_W = 4
);
    logic [31:0]       pcF;
    logic              branchF;
    logic              stallF;
    logic              predict_takenF;
    logic [HIST_W-1:0] ghr_snapF;
    logic              update_en;
    logic [31:0]       update_pc;
    logic              update_taken;
    logic [HIST_W-1:0] update_snap;
    logic              mispredict;
    logic              ready;

    // Pipeline side
    modport master (
        output pcF, branchF, stallF,
        output update_en, update_pc, update_taken, update_snap, mispredict,
        input  predict_takenF, ghr_snapF, ready
    );

    // Predictor side
    modport slave (
        input  pcF, branchF, stallF,
        input  update_en, update_pc, update_taken, update_snap, mispredict,
        output predict_takenF, ghr_snapF, ready
    );
endinterface

// File: rtl/gshare_predictor.sv
// Global-history branch predictor: speculative GHR plus a PHT of saturating counters, swept to weakly-not-taken after reset.
// Prediction is combinational (0 cycles); training and GHR updates land at the next clk edge.
// No backpressure: every request is accepted; ready is low during the DEPTH-cycle init sweep, when predictions read 0.
//
// Ports: clk, rst (synchronous, active-low), bp (gshare_if.slave: fetch predict port, resolve/train port, ready).
// Build option: define GSHARE_XOR_EN for the XOR-hashed (gshare) index; left undefined the index is the
// gselect concatenation {history, pc bits}.
module gshare_predictor #(
    parameter int INDEX_W = 6,
    parameter int HIST_W  = 4,   // 1..INDEX_W
    parameter int CNT_W   = 2    // 1..4
) (
    input  logic    clk,
    input  logic    rst,
    gshare_if.slave bp
);
    localparam int                 DEPTH    = 1 << INDEX_W;
    localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(DEPTH - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [INDEX_W-1:0] init_cnt_q, init_cnt_d;
    logic [HIST_W-1:0]  ghr_q, ghr_d;
    logic [CNT_W-1:0]   pht_q [DEPTH];

    logic               pht_we;
    logic [INDEX_W-1:0] pht_waddr;
    logic [CNT_W-1:0]   pht_wdat;

    logic               ready;
    logic               predict_taken;
    logic [INDEX_W-1:0] fetch_idx;
    logic [INDEX_W-1:0] upd_idx;

    // Only the word-index bits of the PCs feed the table.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bp.pcF[31:INDEX_W+2], bp.pcF[1:0],
                              bp.update_pc[31:INDEX_W+2], bp.update_pc[1:0]};

    // PHT index from word-address bits and a history value.
    function automatic logic [INDEX_W-1:0] pht_idx(input logic [INDEX_W-1:0] pc_bits,
                                                   input logic [HIST_W-1:0]  hist);
        logic [INDEX_W-1:0] hist_x;
        hist_x = '0;
        hist_x[HIST_W-1:0] = hist;
`ifdef GSHARE_XOR_EN
        return pc_bits ^ hist_x;
`else
        // History in the top HIST_W bits, low pc bits below; the mask is empty when HIST_W==INDEX_W.
        return (hist_x << (INDEX_W - HIST_W)) | (pc_bits & ({INDEX_W{1'b1}} >> HIST_W));
`endif
    endfunction

    // Shift a new outcome into the LSB; written without part-selects so HIST_W=1 works.
    function automatic logic [HIST_W-1:0] hist_push(input logic [HIST_W-1:0] hist,
                                                    input logic              bit_in);
        logic [HIST_W-1:0] h;
        h    = hist << 1;
        h[0] = bit_in;
        return h;
    endfunction

    function automatic logic [CNT_W-1:0] sat_next(input logic [CNT_W-1:0] cnt,
                                                  input logic             taken);
        if (taken) begin
            return (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        end
        return (cnt == '0) ? cnt : cnt - 1'b1;
    endfunction

    assign ready     = (state_q == ST_RUN);
    assign fetch_idx = pht_idx(bp.pcF[INDEX_W+1:2], ghr_q);
    assign upd_idx   = pht_idx(bp.update_pc[INDEX_W+1:2], bp.update_snap);

    // Reads the registered table, so a same-cycle update to this entry is not visible yet.
    assign predict_taken     = bp.branchF & ready & pht_q[fetch_idx][CNT_W-1];
    assign bp.predict_takenF = predict_taken;
    assign bp.ghr_snapF      = ghr_q;
    assign bp.ready          = ready;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        ghr_d      = ghr_q;
        pht_we     = 1'b0;
        pht_waddr  = init_cnt_q;
        pht_wdat   = CNT_INIT;

        case (state_q)
            ST_INIT: begin
                // One entry per cycle; updates are dropped and history stays cleared.
                pht_we     = 1'b1;
                init_cnt_d = init_cnt_q + 1'b1;
                ghr_d      = '0;
                if (init_cnt_q == LAST_IDX) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bp.update_en) begin
                    pht_we    = 1'b1;
                    pht_waddr = upd_idx;
                    pht_wdat  = sat_next(pht_q[upd_idx], bp.update_taken);
                end
                // Recovery wins: the Fetch instruction is on the wrong path and gets flushed.
                if (bp.update_en && bp.mispredict) begin
                    ghr_d = hist_push(bp.update_snap, bp.update_taken);
                end else if (bp.branchF && !bp.stallF) begin
                    ghr_d = hist_push(ghr_q, predict_taken);
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            ghr_q      <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            ghr_q      <= ghr_d;
        end
    end

    // Table contents need no reset value: the init sweep rewrites every entry.
    always_ff @(posedge clk) begin
        if (rst && pht_we) begin
            pht_q[pht_waddr] <= pht_wdat;
        end
    end
endmodule
